// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC AXI4-Stream sources onto one egress.
// Define AXIS_ARB_PKT_COUNT_EN to enable the per-source completed-packet counters.
module axis_packet_arbiter #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                            AXI_clock,
  input  logic                            AXI_reset,
  input  logic                            arb_enable,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic [NUM_SRC*DATA_WIDTH/8-1:0] S_AXIS_tkeep,
  input  logic [NUM_SRC-1:0]              S_AXIS_tlast,
  input  logic [NUM_SRC-1:0]              S_AXIS_tvalid,
  output logic [NUM_SRC-1:0]              S_AXIS_tready,
  output logic [DATA_WIDTH-1:0]           M_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0]         M_AXIS_tkeep,
  output logic                            M_AXIS_tlast,
  output logic                            M_AXIS_tvalid,
  input  logic                            M_AXIS_tready,
  output logic [NUM_SRC-1:0]              grant,
  output logic                            busy,
  output logic [NUM_SRC*CNT_WIDTH-1:0]    pkt_count
);

  localparam int unsigned KeepW = DATA_WIDTH / 8;
  localparam int unsigned PtrW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e              state_q, state_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]     pick_idx;
  logic                pick_vld;
  logic [PtrW-1:0]     gnt_idx;
  logic [PtrW:0]       scan_w;
  logic                xfer_last;

  // Scan sources starting just after the last winner, wrapping modulo NUM_SRC.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    scan_w   = '0;
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      scan_w = {1'b0, rr_ptr_q} + (PtrW+1)'(off);
      if (scan_w >= (PtrW+1)'(NUM_SRC)) begin
        scan_w = scan_w - (PtrW+1)'(NUM_SRC);
      end
      if (!pick_vld && S_AXIS_tvalid[scan_w[PtrW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan_w[PtrW-1:0];
      end
    end
  end

  // grant_q is zero outside LOCKED, so the one-hot mux also yields the IDLE output values.
  always_comb begin
    M_AXIS_tdata  = '0;
    M_AXIS_tkeep  = '0;
    M_AXIS_tlast  = 1'b0;
    M_AXIS_tvalid = 1'b0;
    gnt_idx       = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        M_AXIS_tdata  = S_AXIS_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        M_AXIS_tkeep  = S_AXIS_tkeep[i*KeepW +: KeepW];
        M_AXIS_tlast  = S_AXIS_tlast[i];
        M_AXIS_tvalid = S_AXIS_tvalid[i];
        gnt_idx       = PtrW'(i);
      end
    end
  end

  assign S_AXIS_tready = grant_q & {NUM_SRC{M_AXIS_tready}};
  assign xfer_last     = M_AXIS_tvalid & M_AXIS_tready & M_AXIS_tlast;
  assign grant         = grant_q;
  assign busy          = (state_q == StLocked);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (arb_enable && pick_vld) begin
          state_d = StLocked;
          grant_d = NUM_SRC'(1) << pick_idx;
        end
      end
      StLocked: begin
        if (xfer_last) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = gnt_idx;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge AXI_clock or posedge AXI_reset) begin
    if (AXI_reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= PtrW'(NUM_SRC - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef AXIS_ARB_PKT_COUNT_EN
  logic [NUM_SRC-1:0][CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge AXI_clock or posedge AXI_reset) begin
    if (AXI_reset) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (xfer_last && grant_q[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign pkt_count = cnt_q;
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed self-checking bench for axis_packet_arbiter (NUM_SRC=2, DATA_WIDTH=64, CNT_WIDTH=4).
module tb_axis_packet_arbiter;

  localparam int NS = 2;
  localparam int DW = 64;
  localparam int CW = 4;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic [NS*DW-1:0]     s_tdata;
  logic [NS*DW/8-1:0]   s_tkeep;
  logic [NS-1:0]        s_tlast;
  logic [NS-1:0]        tv;
  logic [NS-1:0]        s_tready;
  logic [DW-1:0]        m_tdata;
  logic [DW/8-1:0]      m_tkeep;
  logic                 m_tlast;
  logic                 m_tvalid;
  logic                 m_tready;
  logic [NS-1:0]        grant;
  logic                 busy;
  logic [NS*CW-1:0]     pkt_count;

  int total = 0;
  int bad   = 0;
  int beat[NS];
  int pkt[NS];
  int len[NS];
  logic [7:0] cnt_exp;

  axis_packet_arbiter #(
    .NUM_SRC   (NS),
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .AXI_clock    (clk),
    .AXI_reset    (rst),
    .arb_enable   (en),
    .S_AXIS_tdata (s_tdata),
    .S_AXIS_tkeep (s_tkeep),
    .S_AXIS_tlast (s_tlast),
    .S_AXIS_tvalid(tv),
    .S_AXIS_tready(s_tready),
    .M_AXIS_tdata (m_tdata),
    .M_AXIS_tkeep (m_tkeep),
    .M_AXIS_tlast (m_tlast),
    .M_AXIS_tvalid(m_tvalid),
    .M_AXIS_tready(m_tready),
    .grant        (grant),
    .busy         (busy),
    .pkt_count    (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mkdata(input int src, input int p, input int b);
    return {8'(8'hA0 + src), 24'(p), 32'(b)};
  endfunction

  task automatic drive_src();
    for (int i = 0; i < NS; i++) begin
      s_tdata[i*DW +: DW] = mkdata(i, pkt[i], beat[i]);
      s_tlast[i]          = (beat[i] == len[i] - 1);
      s_tkeep[i*8 +: 8]   = (beat[i] == len[i] - 1) ? 8'h0F : 8'hFF;
    end
  endtask

  // Source side: a beat advances only when the DUT accepted it on this edge.
  task automatic cycle();
    logic [NS-1:0] x;
    x = s_tready & tv;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (x[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          pkt[i]  = pkt[i] + 1;
        end else begin
          beat[i] = beat[i] + 1;
        end
      end
    end
    drive_src();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " grant"}, 64'(grant), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " m_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, " m_tdata"}, m_tdata, 64'd0);
    chk({tag, " s_tready"}, 64'(s_tready), 64'd0);
  endtask

  task automatic chk_beat(input string tag, input int src, input int p, input int b,
                          input logic last);
    chk({tag, " grant"}, 64'(grant), 64'(1) << src);
    chk({tag, " busy"}, 64'(busy), 64'd1);
    chk({tag, " m_tvalid"}, 64'(m_tvalid), 64'd1);
    chk({tag, " m_tdata"}, m_tdata, mkdata(src, p, b));
    chk({tag, " m_tlast"}, 64'(m_tlast), 64'(last));
    chk({tag, " m_tkeep"}, 64'(m_tkeep), last ? 64'h0F : 64'hFF);
    chk({tag, " s_tready"}, 64'(s_tready), m_tready ? (64'(1) << src) : 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    tv       = '0;
    m_tready = 1'b1;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    for (int i = 0; i < NS; i++) begin
      beat[i] = 0;
      pkt[i]  = 0;
      len[i]  = 3;
    end
    drive_src();
    #1;
    chk_idle("reset");
    chk("reset pkt_count", 64'(pkt_count), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    en  = 1'b1;
    tv  = 2'b11;
    #1;

    // 1: both sources busy, strict alternation with one dead cycle between packets
    for (int p = 0; p < 4; p++) begin
      chk_idle("t1 idle");
      cycle();
      for (int b = 0; b < 3; b++) begin
        chk_beat("t1 beat", p % 2, p / 2, b, b == 2);
        cycle();
      end
    end

    // 2: source 1 stalls mid-packet while source 0 waits
    chk_idle("t2 idle");
    tv = 2'b10;
    cycle();
    tv = 2'b11;
    #1;
    chk_beat("t2 A", 1, 2, 0, 1'b0);
    cycle();
    chk_beat("t2 B", 1, 2, 1, 1'b0);
    cycle();
    tv[1] = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t2 stall m_tvalid", 64'(m_tvalid), 64'd0);
      chk("t2 stall grant", 64'(grant), 64'd2);
      chk("t2 stall s_tready", 64'(s_tready), 64'd2);
      cycle();
    end
    tv[1] = 1'b1;
    #1;
    chk_beat("t2 C", 1, 2, 2, 1'b1);
    cycle();
    chk_idle("t2 dead");
    cycle();
    for (int b = 0; b < 3; b++) begin
      chk_beat("t2 src0", 0, 2, b, b == 2);
      cycle();
    end

    // 3: egress back-pressure toggling across a 4-beat packet
    len[1] = 4;
    drive_src();
    #1;
    chk_idle("t3 idle");
    cycle();
    for (int k = 0; k < 7; k++) begin
      m_tready = (k % 2 == 0);
      #1;
      chk_beat("t3 beat", 1, 3, (k + 1) / 2, ((k + 1) / 2) == 3);
      cycle();
    end
    m_tready = 1'b1;
    #1;
    chk_idle("t3 end");
    len[1] = 3;
    drive_src();

    // 4: enable low blocks grants; dropping it mid-packet lets the packet finish
    en = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk_idle("t4 disabled");
      cycle();
    end
    len[0] = 5;
    drive_src();
    en = 1'b1;
    #1;
    cycle();
    for (int b = 0; b < 5; b++) begin
      if (b == 2) en = 1'b0;
      #1;
      chk_beat("t4 beat", 0, 3, b, b == 4);
      cycle();
    end
    for (int k = 0; k < 3; k++) begin
      chk_idle("t4 after");
      cycle();
    end
    len[0] = 3;
    drive_src();
    en = 1'b1;
    #1;

    // 5: reset in the middle of a packet
    cycle();
    chk_beat("t5 beat0", 1, 4, 0, 1'b0);
    cycle();
    chk_beat("t5 beat1", 1, 4, 1, 1'b0);
    cycle();
    rst = 1'b1;
    #1;
    chk_idle("t5 in reset");
    chk("t5 reset pkt_count", 64'(pkt_count), 64'd0);
    beat[1] = 0;
    drive_src();
    cycle();
    rst = 1'b0;
    #1;
    chk_idle("t5 released");
    cycle();
    for (int b = 0; b < 3; b++) begin
      chk_beat("t5 src0 first", 0, 4, b, b == 2);
      cycle();
    end
    chk_idle("t5 end");
`ifdef AXIS_ARB_PKT_COUNT_EN
    cnt_exp = 8'h01;
`else
    cnt_exp = 8'h00;
`endif
    chk("t5 pkt_count", 64'(pkt_count), 64'(cnt_exp));

    // 6: single requester is re-granted every packet; counter wraps at 16
    tv     = 2'b01;
    len[0] = 1;
    drive_src();
    #1;
    for (int n = 0; n < 16; n++) begin
      cycle();
      chk_beat("t6 regrant", 0, 5 + n, 0, 1'b1);
      cycle();
      if (n == 14) begin
        chk("t6 pkt_count wrap", 64'(pkt_count), 64'd0);
      end
    end
    chk("t6 pkt_count final", 64'(pkt_count), 64'(cnt_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
